// File: rtl/wb_mux_pipe_pkg.sv
// Shared writeback definitions: default widths, source indices and the select-width helper.
package wb_pkg;

   localparam int WB_WIDTH_DEF   = 32;
   localparam int WB_NUM_SRC_DEF = 4;

   localparam int WB_SRC_RES = 0;
   localparam int WB_SRC_MEM = 1;
   localparam int WB_SRC_PC4 = 2;
   localparam int WB_SRC_IMM = 3;

   typedef logic [WB_WIDTH_DEF-1:0] wb_word_t;

   // Select field is never narrower than one bit, even for a degenerate source count.
   function automatic int selWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_mux_pipe_if.sv
// Writeback stage bus: source words plus select on the input side, registered word on the output side.
interface wb_mux_pipe_if
   import wb_pkg::*;
#(
   parameter int WIDTH   = WB_WIDTH_DEF,
   parameter int NUM_SRC = WB_NUM_SRC_DEF,
   parameter int SEL_W   = selWidth(NUM_SRC)
);

   logic [NUM_SRC*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]         in_sel;
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     err_sel;
   logic                     err_clr;

   modport master (
      output in_data, in_sel, in_valid, out_ready, err_clr,
      input  in_ready, out_data, out_valid, err_sel
   );

   modport slave (
      input  in_data, in_sel, in_valid, out_ready, err_clr,
      output in_ready, out_data, out_valid, err_sel
   );

endinterface

// File: rtl/wb_mux_pipe_comb.sv
// Combinational NUM_SRC:1 word selector; an out-of-range select yields zero and is flagged.
module wb_mux_comb
   import wb_pkg::*;
#(
   parameter int WIDTH   = WB_WIDTH_DEF,
   parameter int NUM_SRC = WB_NUM_SRC_DEF,
   parameter int SEL_W   = selWidth(NUM_SRC)
) (
   input  logic [NUM_SRC*WIDTH-1:0] inData,
   input  logic [SEL_W-1:0]         inSel,
   output logic [WIDTH-1:0]         selWord,
   output logic                     illegal
);

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      selWord = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (inSel == SEL_W'(k)) selWord = inData[k*WIDTH +: WIDTH];
      end
   end

   assign illegal = ({{(32-SEL_W){1'b0}}, inSel} >= 32'(NUM_SRC));

endmodule

// File: rtl/wb_mux_pipe.sv
// Registered writeback select stage: N:1 mux feeding an output register backed by a one-entry skid buffer.
module wb_mux_pipe
   import wb_pkg::*;
#(
   parameter int WIDTH   = WB_WIDTH_DEF,
   parameter int NUM_SRC = WB_NUM_SRC_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   wb_mux_pipe_if.slave  bus
);

   localparam int SEL_W = selWidth(NUM_SRC);

   logic [WIDTH-1:0] selWord;
   logic             selIllegal;
   logic [WIDTH-1:0] outData;
   logic             outValid;
   logic [WIDTH-1:0] skidData;
   logic             skidValid;
   logic             errSel;
   logic             outFree;
   logic             accept;

   wb_mux_comb #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_mux (
      .inData  (bus.in_data),
      .inSel   (bus.in_sel),
      .selWord (selWord),
      .illegal (selIllegal)
   );

   // Ready depends only on skid occupancy, so out_ready never reaches in_ready combinationally.
   assign outFree = !outValid || bus.out_ready;
   assign accept  = bus.in_valid && !skidValid;

   // NOTE: state registers use non-blocking assignments; data registers are reset too because
   // out_data must read zero during and right after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outData   <= '0;
         outValid  <= 1'b0;
         skidData  <= '0;
         skidValid <= 1'b0;
      end else if (skidValid) begin
         if (outFree) begin
            outData   <= skidData;
            outValid  <= 1'b1;
            skidValid <= 1'b0;
         end
      end else if (accept) begin
         if (outFree) begin
            outData  <= selWord;
            outValid <= 1'b1;
         end else begin
            skidData  <= selWord;
            skidValid <= 1'b1;
         end
      end else if (outFree) begin
         outValid <= 1'b0;
      end
   end

   // Set has priority over clear so an illegal select in the clearing cycle is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     errSel <= 1'b0;
      else if (accept && selIllegal) errSel <= 1'b1;
      else if (bus.err_clr)           errSel <= 1'b0;
   end

   assign bus.in_ready  = !skidValid;
   assign bus.out_data  = outData;
   assign bus.out_valid = outValid;
   assign bus.err_sel   = errSel;

endmodule

// File: tb/tb_wb_mux_pipe.sv
// Bench for wb_mux_pipe: a 4-source and a 3-source instance share stimulus and a transaction-level FIFO model.
module tb_wb_mux_pipe;
   import wb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   wb_mux_pipe_if #(.WIDTH(WB_WIDTH_DEF), .NUM_SRC(4)) bus4 ();
   wb_mux_pipe_if #(.WIDTH(WB_WIDTH_DEF), .NUM_SRC(3)) bus3 ();

   wb_mux_pipe #(.WIDTH(WB_WIDTH_DEF), .NUM_SRC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   wb_mux_pipe #(.WIDTH(WB_WIDTH_DEF), .NUM_SRC(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   int       checks    = 0;
   int       failures  = 0;
   int       accepted  = 0;
   int       delivered = 0;
   wb_word_t src[4];
   wb_word_t q4[$];
   wb_word_t q3[$];
   logic     err3Exp   = 1'b0;

   // One cycle: drive at the falling edge, update the model with the transfers the next rising
   // edge performs, then compare everything at the following falling edge.
   task automatic step(input logic v, input logic [1:0] sel, input logic ordy, input logic clr);
      logic acc;
      bus4.in_data   = {src[3], src[2], src[1], src[0]};
      bus3.in_data   = {src[2], src[1], src[0]};
      bus4.in_sel    = sel;
      bus3.in_sel    = sel;
      bus4.in_valid  = v;
      bus3.in_valid  = v;
      bus4.out_ready = ordy;
      bus3.out_ready = ordy;
      bus4.err_clr   = clr;
      bus3.err_clr   = clr;
      acc = v && (q4.size() < 2);
      if (q4.size() > 0 && ordy) begin
         void'(q4.pop_front());
         void'(q3.pop_front());
         delivered++;
      end
      if (acc) begin
         q4.push_back(src[sel]);
         q3.push_back((sel < 2'd3) ? src[sel] : '0);
         accepted++;
      end
      if (acc && sel == 2'd3) err3Exp = 1'b1;
      else if (clr)           err3Exp = 1'b0;
      @(negedge clk);
      checks++;
      if (bus4.in_ready !== (q4.size() < 2)) begin
         failures++; $display("FAIL in_ready4 got=%b want=%b", bus4.in_ready, q4.size() < 2);
      end
      checks++;
      if (bus4.out_valid !== (q4.size() > 0)) begin
         failures++; $display("FAIL out_valid4 got=%b want=%b", bus4.out_valid, q4.size() > 0);
      end
      if (q4.size() > 0) begin
         checks++;
         if (bus4.out_data !== q4[0]) begin
            failures++; $display("FAIL out_data4 got=%h want=%h", bus4.out_data, q4[0]);
         end
      end
      checks++;
      if (bus3.in_ready !== (q3.size() < 2)) begin
         failures++; $display("FAIL in_ready3 got=%b want=%b", bus3.in_ready, q3.size() < 2);
      end
      checks++;
      if (bus3.out_valid !== (q3.size() > 0)) begin
         failures++; $display("FAIL out_valid3 got=%b want=%b", bus3.out_valid, q3.size() > 0);
      end
      if (q3.size() > 0) begin
         checks++;
         if (bus3.out_data !== q3[0]) begin
            failures++; $display("FAIL out_data3 got=%h want=%h", bus3.out_data, q3[0]);
         end
      end
      checks++;
      if (bus4.err_sel !== 1'b0) begin
         failures++; $display("FAIL err_sel4 got=%b want=0", bus4.err_sel);
      end
      checks++;
      if (bus3.err_sel !== err3Exp) begin
         failures++; $display("FAIL err_sel3 got=%b want=%b", bus3.err_sel, err3Exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      src   = '{default: '0};
      bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.err_clr = 1'b0; bus4.in_sel = '0; bus4.in_data = '0;
      bus3.in_valid = 1'b0; bus3.out_ready = 1'b0; bus3.err_clr = 1'b0; bus3.in_sel = '0; bus3.in_data = '0;
      #1;
      checks++;
      if (bus4.out_valid !== 1'b0 || bus4.out_data !== '0 || bus4.in_ready !== 1'b1 || bus4.err_sel !== 1'b0) begin
         failures++;
         $display("FAIL reset4 got v=%b d=%h r=%b e=%b want v=0 d=0 r=1 e=0",
                  bus4.out_valid, bus4.out_data, bus4.in_ready, bus4.err_sel);
      end
      checks++;
      if (bus3.out_valid !== 1'b0 || bus3.out_data !== '0 || bus3.in_ready !== 1'b1 || bus3.err_sel !== 1'b0) begin
         failures++;
         $display("FAIL reset3 got v=%b d=%h r=%b e=%b want v=0 d=0 r=1 e=0",
                  bus3.out_valid, bus3.out_data, bus3.in_ready, bus3.err_sel);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 2'd0, 1'b1, 1'b0);
   endtask

   task automatic test_basic();
      src[WB_SRC_RES] = 32'd400;
      src[WB_SRC_MEM] = 32'd500;
      src[WB_SRC_PC4] = 32'h0000_0104;
      src[WB_SRC_IMM] = 32'hFFFF_FFFF;
      step(1'b1, 2'(WB_SRC_RES), 1'b1, 1'b0);
      checks++;
      if (bus4.out_data !== 32'd400) begin
         failures++; $display("FAIL basic_first got=%0d want=400", bus4.out_data);
      end
      step(1'b1, 2'(WB_SRC_MEM), 1'b1, 1'b0);
      checks++;
      if (bus4.out_data !== 32'd500) begin
         failures++; $display("FAIL basic_second got=%0d want=500", bus4.out_data);
      end
      step(1'b1, 2'(WB_SRC_IMM), 1'b1, 1'b0);
      step(1'b1, 2'(WB_SRC_PC4), 1'b1, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0);
   endtask

   task automatic test_stall();
      step(1'b1, 2'd1, 1'b0, 1'b0);
      step(1'b1, 2'd0, 1'b0, 1'b0);
      step(1'b1, 2'd2, 1'b0, 1'b0);
      checks++;
      if (bus4.in_ready !== 1'b0 || bus4.out_data !== 32'd500) begin
         failures++;
         $display("FAIL stall_full got r=%b d=%0d want r=0 d=500", bus4.in_ready, bus4.out_data);
      end
      step(1'b0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (bus4.out_data !== 32'd400 || bus4.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_drain got v=%b d=%0d want v=1 d=400", bus4.out_valid, bus4.out_data);
      end
      step(1'b0, 2'd0, 1'b1, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int startDel;
      startDel = delivered;
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 4; k++) src[k] = wb_word_t'($urandom);
         step(1'b1, 2'(i % 4), 1'b1, 1'b0);
      end
      step(1'b0, 2'd0, 1'b1, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (delivered - startDel !== 8) begin
         failures++; $display("FAIL b2b_count got=%0d want=8", delivered - startDel);
      end
   endtask

   task automatic test_err();
      src[0] = 32'h1111_1111; src[1] = 32'h2222_2222; src[2] = 32'h3333_3333; src[3] = 32'h4444_4444;
      step(1'b1, 2'd3, 1'b1, 1'b0);
      checks++;
      if (bus3.err_sel !== 1'b1 || bus3.out_data !== '0) begin
         failures++;
         $display("FAIL err_set got e=%b d=%h want e=1 d=0", bus3.err_sel, bus3.out_data);
      end
      step(1'b0, 2'd0, 1'b1, 1'b1);
      checks++;
      if (bus3.err_sel !== 1'b0) begin
         failures++; $display("FAIL err_clr got=%b want=0", bus3.err_sel);
      end
      step(1'b1, 2'd3, 1'b1, 1'b1);
      checks++;
      if (bus3.err_sel !== 1'b1) begin
         failures++; $display("FAIL err_set_wins got=%b want=1", bus3.err_sel);
      end
      step(1'b1, 2'd2, 1'b1, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 4; k++) src[k] = wb_word_t'($urandom);
      step(1'b1, 2'd0, 1'b0, 1'b0);
      step(1'b1, 2'd1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus4.out_valid !== 1'b0 || bus4.out_data !== '0 || bus4.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset4 got v=%b d=%h r=%b want v=0 d=0 r=1", bus4.out_valid, bus4.out_data, bus4.in_ready);
      end
      checks++;
      if (bus3.out_valid !== 1'b0 || bus3.out_data !== '0 || bus3.err_sel !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset3 got v=%b d=%h e=%b want v=0 d=0 e=0", bus3.out_valid, bus3.out_data, bus3.err_sel);
      end
      q4.delete();
      q3.delete();
      err3Exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(1'b0, 2'd0, 1'b1, 1'b0);
   endtask

   task automatic test_toggle_ready();
      int startAcc, startDel;
      startAcc = accepted;
      startDel = delivered;
      for (int c = 0; c < 80 && (accepted - startAcc) < 10; c++) begin
         for (int k = 0; k < 4; k++) src[k] = wb_word_t'($urandom);
         step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), logic'(c % 2), 1'b0);
      end
      checks++;
      if (accepted - startAcc !== 10) begin
         failures++; $display("FAIL toggle_accepts got=%0d want=10", accepted - startAcc);
      end
      for (int c = 0; c < 20 && q4.size() > 0; c++) step(1'b0, 2'd0, logic'(c % 2), 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (delivered - startDel !== accepted - startAcc) begin
         failures++;
         $display("FAIL toggle_deliveries got=%0d want=%0d", delivered - startDel, accepted - startAcc);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_err();
      test_reset_mid();
      test_toggle_ready();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_mux_pipe.md
Name: wb_mux_pipe

Overview:
Parametrised N-source writeback select stage for the datapath. It generalises the fixed 2:1 32-bit memory/result writeback mux to NUM_SRC sources of WIDTH bits, and registers the selected word behind a valid/ready handshake. A one-entry skid buffer sustains full throughput with a registered ready. It sits between the execute/memory stage outputs and the register-file write port.

Parameters:
WIDTH, 32, data width of each source and of the output
NUM_SRC, 4, number of selectable sources (2..16)
SEL_W, $clog2(NUM_SRC) (minimum 1), select field width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_SRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH]
in_sel  input  SEL_W  source index; sampled with in_valid
in_valid  input  1  upstream word valid
in_ready  output  1  stage can accept a word this cycle
out_data  output  WIDTH  selected, registered word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
err_sel  output  1  sticky flag: an accepted in_sel was >= NUM_SRC
err_clr  input  1  synchronous clear of err_sel

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, skid_valid=0, skid_data=0, err_sel=0. in_ready reads 1 while in reset, but no transfer occurs while rst_n is low.
- Handshakes:
  - Accept: in_valid && in_ready at a rising edge.
  - Deliver: out_valid && out_ready at a rising edge.
- in_ready = !skid_valid. It is a registered-state function with no combinational path from out_ready.
- Selection: sel_word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_SRC, otherwise all-zero.
- Latency: 1 cycle from accept to out_valid when the output register is empty or draining.
- Per-edge update, where out_free = !out_valid || out_ready:
  - skid_valid && out_free: out <- skid, skid_valid <- 0. in_ready was 0, so no accept occurs this cycle.
  - !skid_valid && accept && out_free: out_data <- sel_word, out_valid <- 1.
  - !skid_valid && accept && !out_free: skid_data <- sel_word, skid_valid <- 1. out_data is held.
  - !skid_valid && !accept && out_free: out_valid <- 0. out_data holds its last value, which is don't-care.
  - Stall (!out_free): out_data and out_valid are held stable until delivery.
- Ordering: strict FIFO. At most 2 words in flight (output register + skid).
- Throughput: one word per cycle when out_ready is held high.
- err_sel:
  - Set on any accept with in_sel >= NUM_SRC.
  - err_clr clears it.
  - Simultaneous set and clear: set wins.
  - Only reset or err_clr clears it.
- When NUM_SRC is a power of two, the illegal-select path is unreachable and err_sel stays 0.
- Reset asserted mid-transfer discards both buffered words immediately. Nothing is delivered after reset deassertion until a new accept.

Decomposition:
- Shared package wb_pkg holds:
  - WB_WIDTH_DEF = 32
  - WB_NUM_SRC_DEF = 4
  - source-index constants: WB_SRC_RES = 0, WB_SRC_MEM = 1, WB_SRC_PC4 = 2, WB_SRC_IMM = 3
  - typedef wb_word_t (logic [WB_WIDTH_DEF-1:0])
- One sub-module is natural: wb_mux_comb, the parametrised combinational NUM_SRC:1 selector with the zero-on-illegal rule. The top level instantiates it and owns the output/skid registers and err_sel.

Test Plan:
- WIDTH=32, NUM_SRC=4 (defaults); sources {0:400, 1:500, 2:0x104, 3:0xFFFF_FFFF}; out_ready=1; sel=0 then sel=1 on consecutive cycles -> out_data 400, then 500, each 1 cycle after accept; in_ready stays 1.
- out_ready=0; accept sel=1 (500) then sel=0 (400) -> out_data=500 held with out_valid=1; skid full; in_ready=0 on the third cycle. Raise out_ready -> 500 delivered, then 400, then out_valid=0.
- Streaming: 8 back-to-back accepts, sel cycling 0..3, out_ready=1 -> 8 deliveries in order with no bubbles.
- NUM_SRC=3; accept sel=3 -> out_data=0, err_sel=1 on the next edge. err_clr pulse -> err_sel=0. err_clr together with another sel=3 accept -> err_sel stays 1.
- Two words buffered (out_ready=0); rst_n pulled low asynchronously mid-cycle -> out_valid=0 and out_data=0 immediately. After release, in_ready=1 and no stale delivery occurs.
- out_ready toggled every cycle during a 10-word random stream -> every word delivered exactly once, in order, with out_data stable whenever out_valid && !out_ready.
